// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder slice reused per clock
// Optional subtract mode: define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_a, shift_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last, bit_s, bit_c;
  logic [WIDTH-1:0] load_b;
  logic             load_c;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);
  assign bit_s  = shift_a[0] ^ shift_b[0] ^ carry;
  assign bit_c  = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);

`ifdef SERIAL_ADDER_SUB_EN
  // a - b computed as a + ~b + 1
  assign load_b = sub ? ~b : b;
  assign load_c = sub | cin;
`else
  assign load_b = b;
  assign load_c = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Result bits fill shift_a from the top as operand bits leave the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a <= '0;
      shift_b <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      shift_a <= a;
      shift_b <= load_b;
      carry   <= load_c;
      cnt     <= '0;
    end else if (state == RUN) begin
      shift_a <= {bit_s, shift_a[WIDTH-1:1]};
      shift_b <= {1'b0, shift_b[WIDTH-1:1]};
      carry   <= bit_c;
      cnt     <= cnt + CW'(1);
      if (last) begin
        sum  <= {bit_s, shift_a[WIDTH-1:1]};
        cout <= bit_c;
        ovf  <= bit_c ^ carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] arith(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   t;
    logic         v;
    yy = y;
    cc = ci;
`ifdef SERIAL_ADDER_SUB_EN
    if (s) begin
      yy = ~y;
      cc = 1'b1;
    end
`endif
    t = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    v = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return {v, t[W], t[W-1:0]};
  endfunction

  // Model: remaining RUN cycles plus the pending and published results.
  int           rem = 0;
  logic         m_done = 1'b0;
  logic [W+1:0] pend = '0;
  logic [W+1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      pend   <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem == 0) begin
        if (start) begin
          rem  <= W;
          pend <= arith(a, b, cin, sub);
        end
      end else begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_res  <= pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(rem != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("sum", 64'(sum), 64'(m_res[W-1:0]));
    chk("cout", 64'(cout), 64'(m_res[W]));
    chk("ovf", 64'(ovf), 64'(m_res[W+1]));
  end

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic s, output int lat);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  task automatic expect_res(input string name, input logic [W-1:0] es, input logic ec,
                            input logic eo);
    chk({name, "_sum"}, 64'(sum), 64'(es));
    chk({name, "_cout"}, 64'(cout), 64'(ec));
    chk({name, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    int lat;
    int busy_cyc;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and busy length
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    lat = 1;
    while (!done && lat < 4 * W) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat - 1), 64'(W));
    chk("busy_len", 64'(busy_cyc), 64'(W));
    expect_res("t0f01", 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    expect_res("tff01", 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0, lat);
    expect_res("t7f00c", 8'h80, 1'b0, 1'b1);

    // Start during RUN is ignored
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    expect_res("ignored", 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    run_op(8'h11, 8'h22, 1'b0, 1'b0, lat);
    expect_res("t1122", 8'h33, 1'b0, 1'b0);

    // Start held high across DONE
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    wait_done(lat);
    expect_res("held1", 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    expect_res("held2", 8'h30, 1'b0, 1'b0);

    // Reset during RUN
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    expect_res("abort", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'(0));
    run_op(8'h05, 8'h03, 1'b0, 1'b0, lat);
    expect_res("t0503", 8'h08, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
    expect_res("sub0507", 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, lat);
    expect_res("sub8001", 8'h7F, 1'b1, 1'b1);
`endif

    // Random operations with random gaps and occasional held start
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, W + 3)) @(negedge clk);
    end
    start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
